// File: rtl/missile_pool.sv
// Pool of N_SLOTS missiles launched from the robot position.
// Each slot flies in its latched direction until it leaves the screen or is hit.
module missile_pool #(
    parameter int         N_SLOTS  = 4,
    parameter logic [9:0] STEP     = 10'd50,
    parameter int         CD_TICKS = 10,
    parameter int         X_MAX    = 640,
    parameter int         Y_MAX    = 480,
    parameter int         MARGIN   = 3
) (
    input  logic                    clk_22,
    input  logic                    rst,
    input  logic                    pause,
    input  logic                    shoot_sign,
    input  logic [1:0]              dir,
    input  logic [9:0]              r_x,
    input  logic [9:0]              r_y,
    input  logic [N_SLOTS-1:0]      hit_clear,
    output logic [10*N_SLOTS-1:0]   m_x,
    output logic [10*N_SLOTS-1:0]   m_y,
    output logic [N_SLOTS-1:0]      show_valid,
    output logic                    cd_sign,
    output logic [3:0]              active_cnt
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} slot_e;

    localparam int CW = (CD_TICKS < 2) ? 1 : $clog2(CD_TICKS + 1);
    localparam logic signed [11:0] LO  = 12'(MARGIN);
    localparam logic signed [11:0] XHI = 12'(X_MAX);
    localparam logic signed [11:0] YHI = 12'(Y_MAX);
    localparam logic signed [11:0] STP = {2'b00, STEP};

    slot_e             st_q  [N_SLOTS];
    slot_e             st_d  [N_SLOTS];
    logic [1:0]        dir_q [N_SLOTS];
    logic [1:0]        dir_d [N_SLOTS];
    logic [9:0]        x_q   [N_SLOTS];
    logic [9:0]        x_d   [N_SLOTS];
    logic [9:0]        y_q   [N_SLOTS];
    logic [9:0]        y_d   [N_SLOTS];
    logic signed [11:0] nx   [N_SLOTS];
    logic signed [11:0] ny   [N_SLOTS];
    logic [CW-1:0]     cd_q, cd_d;
    logic              shoot_q, shoot_d;
    logic [N_SLOTS-1:0] off, sel;
    logic              found, req, launch;

    // Candidate move in 12-bit signed space so leaving the screen never wraps.
    always_comb begin
        logic signed [11:0] dx, dy;
        for (int i = 0; i < N_SLOTS; i++) begin
            dx = '0;
            dy = '0;
            unique case (dir_q[i])
                2'b00: dx = STP;
                2'b01: dx = -STP;
                2'b10: dy = -STP;
                2'b11: dy = STP;
            endcase
            nx[i]  = $signed({2'b00, x_q[i]}) + dx;
            ny[i]  = $signed({2'b00, y_q[i]}) + dy;
            off[i] = (nx[i] < LO) || (nx[i] >= XHI) ||
                     (ny[i] < LO) || (ny[i] >= YHI);
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!found && st_q[i] == IDLE) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        req     = shoot_sign & ~shoot_q;
        launch  = req & ~pause & (cd_q == '0) & found;
        shoot_d = shoot_sign;
        for (int i = 0; i < N_SLOTS; i++) begin
            st_d[i]  = st_q[i];
            dir_d[i] = dir_q[i];
            x_d[i]   = x_q[i];
            y_d[i]   = y_q[i];
            if (!pause) begin
                if (st_q[i] == IDLE) begin
                    x_d[i] = r_x;
                    y_d[i] = r_y;
                    if (launch && sel[i]) begin
                        st_d[i]  = ACTIVE;
                        dir_d[i] = dir;
                    end
                end else if (hit_clear[i] || off[i]) begin
                    st_d[i] = IDLE;
                end else begin
                    x_d[i] = nx[i][9:0];
                    y_d[i] = ny[i][9:0];
                end
            end
        end
        cd_d = cd_q;
        if (launch)
            cd_d = CW'(CD_TICKS);
        else if (!pause && cd_q != '0)
            cd_d = cd_q - CW'(1);
    end

    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                st_q[i]  <= IDLE;
                dir_q[i] <= 2'b00;
                x_q[i]   <= 10'd100;
                y_q[i]   <= 10'd140;
            end
            cd_q    <= '0;
            shoot_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                st_q[i]  <= st_d[i];
                dir_q[i] <= dir_d[i];
                x_q[i]   <= x_d[i];
                y_q[i]   <= y_d[i];
            end
            cd_q    <= cd_d;
            shoot_q <= shoot_d;
        end
    end

    always_comb begin
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            show_valid[i]    = (st_q[i] == ACTIVE);
            m_x[10*i +: 10]  = x_q[i];
            m_y[10*i +: 10]  = y_q[i];
            cnt              = cnt + 4'(show_valid[i]);
        end
        active_cnt = cnt;
    end

    assign cd_sign = (cd_q != '0);

endmodule

// File: tb/tb_missile_pool.sv
// Bench for missile_pool: default instance and a no-cooldown instance,
// checked each cycle against a behavioural model plus directed literals.
module tb_missile_pool;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic       shoot = 1'b0;
    logic [1:0] dir = 2'b00;
    logic [9:0] rx = 10'd100;
    logic [9:0] ry = 10'd140;
    logic [3:0] hit = 4'b0000;

    logic [39:0] mx_a, my_a, mx_b, my_b;
    logic [3:0]  sv_a, sv_b, cnt_a, cnt_b;
    logic        cd_a, cd_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    missile_pool dut_a (
        .clk_22(clk), .rst(rst), .pause(pause), .shoot_sign(shoot),
        .dir(dir), .r_x(rx), .r_y(ry), .hit_clear(hit),
        .m_x(mx_a), .m_y(my_a), .show_valid(sv_a),
        .cd_sign(cd_a), .active_cnt(cnt_a)
    );

    missile_pool #(.CD_TICKS(0)) dut_b (
        .clk_22(clk), .rst(rst), .pause(pause), .shoot_sign(shoot),
        .dir(dir), .r_x(rx), .r_y(ry), .hit_clear(hit),
        .m_x(mx_b), .m_y(my_b), .show_valid(sv_b),
        .cd_sign(cd_b), .active_cnt(cnt_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: index 0 = default instance, 1 = no cooldown.
    int  m_act [2][4];
    int  m_x   [2][4];
    int  m_y   [2][4];
    int  m_dir [2][4];
    int  m_cd  [2];
    bit  m_prev;

    always @(posedge clk or negedge rst) begin
        int  free, nx, ny;
        bit  fire, req;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) begin
                    m_act[k][i] = 0;
                    m_x[k][i] = 100;
                    m_y[k][i] = 140;
                    m_dir[k][i] = 0;
                end
                m_cd[k] = 0;
            end
            m_prev = 0;
        end else begin
            req = shoot && !m_prev;
            for (int k = 0; k < 2; k++) begin
                free = -1;
                for (int i = 3; i >= 0; i--)
                    if (m_act[k][i] == 0) free = i;
                fire = req && !pause && m_cd[k] == 0 && free >= 0;
                if (!pause) begin
                    if (m_cd[k] > 0) m_cd[k] = m_cd[k] - 1;
                    for (int i = 0; i < 4; i++) begin
                        if (m_act[k][i] != 0) begin
                            nx = m_x[k][i];
                            ny = m_y[k][i];
                            case (m_dir[k][i])
                                0: nx = nx + 50;
                                1: nx = nx - 50;
                                2: ny = ny - 50;
                                default: ny = ny + 50;
                            endcase
                            if (hit[i] || nx < 3 || nx >= 640 || ny < 3 || ny >= 480)
                                m_act[k][i] = 0;
                            else begin
                                m_x[k][i] = nx;
                                m_y[k][i] = ny;
                            end
                        end else begin
                            m_x[k][i] = rx;
                            m_y[k][i] = ry;
                            if (fire && i == free) begin
                                m_act[k][i] = 1;
                                m_dir[k][i] = dir;
                            end
                        end
                    end
                    if (fire) m_cd[k] = (k == 0) ? 10 : 0;
                end
            end
            m_prev = shoot;
        end
    end

    always @(posedge clk) begin
        logic [39:0] ox, oy;
        logic [3:0]  osv, ocnt;
        logic        ocd;
        int          esv, ecnt;
        string       t;
        #2;
        for (int k = 0; k < 2; k++) begin
            t    = (k == 0) ? "a" : "b";
            ox   = (k == 0) ? mx_a : mx_b;
            oy   = (k == 0) ? my_a : my_b;
            osv  = (k == 0) ? sv_a : sv_b;
            ocnt = (k == 0) ? cnt_a : cnt_b;
            ocd  = (k == 0) ? cd_a : cd_b;
            esv  = 0;
            ecnt = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_act[k][i] != 0) begin
                    esv = esv | (1 << i);
                    ecnt++;
                end
                chk($sformatf("%s_mx%0d", t, i), int'(ox[10*i +: 10]), m_x[k][i]);
                chk($sformatf("%s_my%0d", t, i), int'(oy[10*i +: 10]), m_y[k][i]);
            end
            chk($sformatf("%s_show_valid", t), int'(osv), esv);
            chk($sformatf("%s_active_cnt", t), int'(ocnt), ecnt);
            chk($sformatf("%s_cd_sign", t), int'(ocd), (m_cd[k] != 0) ? 1 : 0);
        end
    end

    task automatic pulse();
        shoot = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
    endtask

    task automatic drain();
        repeat (15) @(negedge clk);
    endtask

    initial begin
        int cdn, ra, rb;
        logic pa, pb;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mx", int'(mx_a[9:0]), 100);
        chk("rst_my", int'(my_a[39:30]), 140);
        chk("rst_sv", int'(sv_a), 0);
        chk("rst_cd", int'(cd_a), 0);
        chk("rst_cnt", int'(cnt_b), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single flight to the right edge with cooldown count.
        pulse();
        chk("fly_x0", int'(mx_a[9:0]), 100);
        chk("fly_sv0", int'(sv_a), 1);
        cdn = int'(cd_a);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("fly_x%0d", k), int'(mx_a[9:0]), 100 + 50 * k);
            cdn += int'(cd_a);
        end
        @(negedge clk);
        chk("fly_retire", int'(sv_a[0]), 0);
        chk("fly_retire_x", int'(mx_a[9:0]), 600);
        cdn += int'(cd_a);
        chk("cd_ticks", cdn, 10);
        drain();

        // Held request launches only once.
        shoot = 1'b1;
        ra = 0; rb = 0; pa = sv_a[0]; pb = sv_b[0];
        repeat (20) begin
            @(negedge clk);
            if (sv_a[0] && !pa) ra++;
            if (sv_b[0] && !pb) rb++;
            pa = sv_a[0]; pb = sv_b[0];
        end
        shoot = 1'b0;
        chk("hold_a", ra, 1);
        chk("hold_b", rb, 1);
        drain();

        // Five pulses two ticks apart.
        for (int p = 0; p < 5; p++) begin
            pulse();
            if (p < 4) @(negedge clk);
        end
        chk("burst_b_cnt", int'(cnt_b), 4);
        chk("burst_b_sv", int'(sv_b), 15);
        chk("burst_b_x3", int'(mx_b[39:30]), 200);
        chk("burst_b_x0", int'(mx_b[9:0]), 500);
        chk("burst_a_cnt", int'(cnt_a), 1);
        drain();

        // Leftward launch near the edge retires without wrap.
        rx = 10'd40; ry = 10'd200; dir = 2'b01;
        @(negedge clk);
        pulse();
        chk("left_sv", int'(sv_a[0]), 1);
        chk("left_x", int'(mx_a[9:0]), 40);
        @(negedge clk);
        chk("left_retire", int'(sv_a[0]), 0);
        chk("left_nowrap", int'(mx_a[9:0]), 40);
        rx = 10'd100; ry = 10'd140; dir = 2'b00;
        drain();

        // Hit with simultaneous request: kill, drop, then refill.
        for (int p = 0; p < 4; p++) begin
            pulse();
            @(negedge clk);
        end
        hit = 4'b0010;
        pulse();
        hit = 4'b0000;
        chk("hit_sv", int'(sv_b), 13);
        chk("hit_cnt", int'(cnt_b), 3);
        @(negedge clk);
        pulse();
        chk("refill_sv", int'(sv_b), 15);
        chk("refill_x1", int'(mx_b[19:10]), 100);
        drain();

        // Pause mid-flight and mid-cooldown.
        pulse();
        repeat (3) @(negedge clk);
        chk("pre_pause_x", int'(mx_a[9:0]), 250);
        pause = 1'b1;
        repeat (5) @(negedge clk);
        chk("pause_x", int'(mx_a[9:0]), 250);
        chk("pause_cd", int'(cd_a), 1);
        chk("pause_sv", int'(sv_a[0]), 1);
        pause = 1'b0;
        @(negedge clk);
        chk("resume_x", int'(mx_a[9:0]), 300);
        repeat (5) @(negedge clk);
        chk("resume_cd_hi", int'(cd_a), 1);
        @(negedge clk);
        chk("resume_cd_lo", int'(cd_a), 0);
        drain();

        // Reset mid-flight aborts it.
        pulse();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_sv", int'(sv_a), 0);
        chk("abort_x", int'(mx_a[9:0]), 100);
        chk("abort_cd", int'(cd_a), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_cnt_a", int'(cnt_a), 0);
        chk("post_rst_cnt_b", int'(cnt_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
